route_sequencer: RTL and testbench

ROUTE_SEQUENCER -- requirements
Module: route_sequencer

---
 rtl/maze_pkg.sv | 46 ++++
 rtl/gap_timer.sv | 41 ++++
 rtl/route_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_route_sequencer.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// ---------------------------------------------------------------------------
// maze_pkg
// Shared types and constants for the maze route sequencer.
//   opcode_e  : command opcodes carried in cmd[15:14]
//   turn_e    : two-bit turn codes packed into the route word
//   state_e   : route_sequencer FSM states
//   GAP_LIM_* : gap timeout limits (fast simulation / real hardware)
// ---------------------------------------------------------------------------
package maze_pkg;

    localparam int GAP_W   = 20;
    localparam int ROUTE_W = 14;

    localparam logic [GAP_W-1:0] GAP_LIM_FAST = 20'd4095;
    localparam logic [GAP_W-1:0] GAP_LIM_SLOW = 20'd1048575;

    // Idle route value: every pair reads "end", so a stray edge ends at once.
    localparam logic [ROUTE_W-1:0] ROUTE_EMPTY = 14'h3FFF;

    typedef enum logic [1:0] {
        OP_CAL   = 2'b00,
        OP_GO    = 2'b01,
        OP_RSVD  = 2'b10,
        OP_ABORT = 2'b11
    } opcode_e;

    typedef enum logic [1:0] {
        TURN_STRAIGHT = 2'b00,
        TURN_LEFT     = 2'b01,
        TURN_RIGHT    = 2'b10,
        TURN_END      = 2'b11
    } turn_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CAL,
        ST_MOVE,
        ST_GAP,
        ST_STOP
    } state_e;

    function automatic logic [GAP_W-1:0] gap_limit(input int fast_sim);
        return (fast_sim != 0) ? GAP_LIM_FAST : GAP_LIM_SLOW;
    endfunction

endpackage

// File: rtl/gap_timer.sv
// ---------------------------------------------------------------------------
// gap_timer
// Counts cycles spent crossing an intersection gap and flags a lost line.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : restart the count at zero (has priority over en)
//   en         : count this cycle
//   expired    : high in the enabled cycle whose increment reaches the limit,
//                so the gap lasts exactly GAP_LIM cycles before timing out
// The 20-bit counter saturates at all-ones and never wraps.
// ---------------------------------------------------------------------------
module gap_timer
    import maze_pkg::*;
#(
    parameter int FAST_SIM = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [GAP_W-1:0] LIM_M1 = gap_limit(FAST_SIM) - GAP_W'(1);

    logic [GAP_W-1:0] count;

    // NOTE: clocked state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create simulation order races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + GAP_W'(1);
        end
    end

    assign expired = en && (count >= LIM_M1);

endmodule

// File: rtl/route_sequencer.sv
// ---------------------------------------------------------------------------
// route_sequencer
// Command-driven sequencer that walks a pre-loaded route of turn codes,
// consuming one turn per intersection (falling edge of line_present).
//   clk, rst_n   : clock, asynchronous active-low reset
//   cmd          : [15:14] opcode, [13:0] seven 2-bit turns, LSB pair first
//   cmd_rdy      : command valid, held until clr_cmd_rdy
//   line_present : line sensed under the robot
//   bmp_n        : bumper, active-low
//   cal_done     : calibration finished pulse
//   clr_cmd_rdy  : one-cycle command acknowledge
//   go           : enable for the PID / speed datapath
//   strt_cal     : one-cycle calibration start
//   veer_lft/rght: steering requests while crossing a gap
//   route_done   : one-cycle pulse when the end-of-route turn is reached
//   lost_err     : line not found within the gap timeout
//   buzz_en      : buzzer while stopped
// All outputs are registered.
// ---------------------------------------------------------------------------
module route_sequencer
    import maze_pkg::*;
#(
    parameter int FAST_SIM = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] cmd,
    input  logic        cmd_rdy,
    input  logic        line_present,
    input  logic        bmp_n,
    input  logic        cal_done,
    output logic        clr_cmd_rdy,
    output logic        go,
    output logic        strt_cal,
    output logic        veer_lft,
    output logic        veer_rght,
    output logic        route_done,
    output logic        lost_err,
    output logic        buzz_en
);

    state_e               state, next_state;
    logic [ROUTE_W-1:0]   route;
    turn_e                turn, turn_next;
    logic                 line_prev;

    opcode_e              op;
    turn_e                head;
    logic                 cmd_valid, is_abort, line_fall;
    logic                 load_route, take_turn;
    logic                 gap_expired;

    logic clr_d, go_d, strt_cal_d, veer_lft_d, veer_rght_d;
    logic route_done_d, lost_err_d, buzz_en_d;

    assign op   = opcode_e'(cmd[15:14]);
    assign head = turn_e'(route[1:0]);

    // cmd_rdy is still high in the cycle our acknowledge is visible, so a
    // command is only taken when no acknowledge is in flight.
    assign cmd_valid = cmd_rdy && !clr_cmd_rdy;
    assign is_abort  = cmd_valid && (op == OP_ABORT);
    assign line_fall = line_prev && !line_present;

    assign load_route = (state == ST_IDLE) && cmd_valid && (op == OP_GO);
    assign take_turn  = (state == ST_MOVE) && (next_state == ST_GAP);
    assign turn_next  = take_turn ? head : turn;

    gap_timer #(
        .FAST_SIM (FAST_SIM)
    ) u_gap_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (take_turn),
        .en      (state == ST_GAP),
        .expired (gap_expired)
    );

    // ---- state register --------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ---- next-state logic -------------------------------------------------
    // Bumper first, then ABORT, then line events, then timeout.
    always_comb begin
        // NOTE: assigning a default before the case keeps every path driven,
        // so no latch is inferred for next_state.
        next_state = state;
        unique case (state)
            ST_IDLE: begin
                if (cmd_valid && (op == OP_CAL)) begin
                    next_state = ST_CAL;
                end else if (cmd_valid && (op == OP_GO)) begin
                    next_state = ST_MOVE;
                end
            end
            ST_CAL: begin
                if (is_abort || cal_done) begin
                    next_state = ST_IDLE;
                end
            end
            ST_MOVE: begin
                if (!bmp_n) begin
                    next_state = ST_STOP;
                end else if (is_abort) begin
                    next_state = ST_IDLE;
                end else if (line_fall) begin
                    next_state = (head == TURN_END) ? ST_IDLE : ST_GAP;
                end
            end
            ST_GAP: begin
                if (!bmp_n) begin
                    next_state = ST_STOP;
                end else if (is_abort) begin
                    next_state = ST_IDLE;
                end else if (line_present) begin
                    next_state = ST_MOVE;
                end else if (gap_expired) begin
                    next_state = ST_STOP;
                end
            end
            ST_STOP: begin
                if (cmd_valid) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // ---- output logic (next values of the registered outputs) -------------
    always_comb begin
        go_d         = (next_state == ST_MOVE) || (next_state == ST_GAP);
        buzz_en_d    = (next_state == ST_STOP);
        // lost_err is set only by a timeout (GAP -> STOP without the bumper)
        // and then held for as long as we stay stopped.
        lost_err_d   = (next_state == ST_STOP) &&
                       (((state == ST_STOP) && lost_err) ||
                        ((state == ST_GAP) && bmp_n));
        strt_cal_d   = (state == ST_IDLE) && cmd_valid && (op == OP_CAL);
        route_done_d = (state == ST_MOVE) && bmp_n && !is_abort &&
                       line_fall && (head == TURN_END);
        veer_lft_d   = (next_state == ST_GAP) && (turn_next == TURN_LEFT);
        veer_rght_d  = (next_state == ST_GAP) && (turn_next == TURN_RIGHT);

        clr_d = 1'b0;
        unique case (state)
            ST_IDLE, ST_STOP: clr_d = cmd_valid;
            ST_CAL:           clr_d = is_abort;
            ST_MOVE, ST_GAP:  clr_d = is_abort && bmp_n;
            default:          clr_d = 1'b0;
        endcase
    end

    // ---- output, route and edge-history registers -------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_cmd_rdy <= 1'b0;
            go          <= 1'b0;
            strt_cal    <= 1'b0;
            veer_lft    <= 1'b0;
            veer_rght   <= 1'b0;
            route_done  <= 1'b0;
            lost_err    <= 1'b0;
            buzz_en     <= 1'b0;
        end else begin
            clr_cmd_rdy <= clr_d;
            go          <= go_d;
            strt_cal    <= strt_cal_d;
            veer_lft    <= veer_lft_d;
            veer_rght   <= veer_rght_d;
            route_done  <= route_done_d;
            lost_err    <= lost_err_d;
            buzz_en     <= buzz_en_d;
        end
    end

    // Route shifts right one turn per intersection, refilling with "end" so
    // seven consumed turns leave ROUTE_EMPTY and the eighth edge ends it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            route     <= ROUTE_EMPTY;
            turn      <= TURN_STRAIGHT;
            line_prev <= 1'b0;
        end else begin
            line_prev <= line_present;
            turn      <= turn_next;
            if (load_route) begin
                route <= cmd[ROUTE_W-1:0];
            end else if (take_turn) begin
                route <= {2'b11, route[ROUTE_W-1:2]};
            end
        end
    end

endmodule

// File: tb/tb_route_sequencer.sv
// ---------------------------------------------------------------------------
// tb_route_sequencer
// Self-checking bench for route_sequencer (FAST_SIM=1). A behavioural model
// keeps the route as a queue of turns and recomputes every registered output
// once per clock; a compare process checks all outputs on each falling edge.
// Directed sequences add literal expectations; a random phase follows.
// ---------------------------------------------------------------------------
module tb_route_sequencer;

    localparam int LIM = 4095;

    logic        clk;
    logic        rst_n;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        line_present;
    logic        bmp_n;
    logic        cal_done;
    logic        clr_cmd_rdy;
    logic        go;
    logic        strt_cal;
    logic        veer_lft;
    logic        veer_rght;
    logic        route_done;
    logic        lost_err;
    logic        buzz_en;

    route_sequencer #(
        .FAST_SIM (1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd          (cmd),
        .cmd_rdy      (cmd_rdy),
        .line_present (line_present),
        .bmp_n        (bmp_n),
        .cal_done     (cal_done),
        .clr_cmd_rdy  (clr_cmd_rdy),
        .go           (go),
        .strt_cal     (strt_cal),
        .veer_lft     (veer_lft),
        .veer_rght    (veer_rght),
        .route_done   (route_done),
        .lost_err     (lost_err),
        .buzz_en      (buzz_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit check_en = 1'b0;
    bit clr_seen = 1'b0;

    // ---- behavioural model ------------------------------------------------
    localparam int M_IDLE = 0, M_CAL = 1, M_MOVE = 2, M_GAP = 3, M_STOP = 4;
    int m_mode;
    int m_route[$];
    int m_turn;
    int m_gap;
    bit m_prev_line;
    bit e_go, e_clr, e_cal, e_vl, e_vr, e_done, e_lost, e_buzz;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] dut_outs();
        return {go, clr_cmd_rdy, strt_cal, veer_lft, veer_rght, route_done, lost_err, buzz_en};
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE;
        m_route.delete();
        m_turn = 0;
        m_gap = 0;
        m_prev_line = 1'b0;
        {e_go, e_clr, e_cal, e_vl, e_vr, e_done, e_lost, e_buzz} = 8'h00;
    endtask

    // One clock of the rules, evaluated with the inputs present at the edge.
    task automatic model_step();
        bit valid, fall;
        int op, t;
        valid = cmd_rdy && !e_clr;
        op    = int'(cmd[15:14]);
        fall  = m_prev_line && !line_present;
        e_clr = 0; e_cal = 0; e_done = 0; e_vl = 0; e_vr = 0;
        case (m_mode)
            M_IDLE: begin
                if (valid) begin
                    e_clr = 1;
                    if (op == 0) begin
                        e_cal = 1;
                        m_mode = M_CAL;
                    end else if (op == 1) begin
                        m_route.delete();
                        for (int i = 0; i < 7; i++) m_route.push_back(int'(cmd[2*i +: 2]));
                        e_go = 1;
                        m_mode = M_MOVE;
                    end
                end
            end
            M_CAL: begin
                if (valid && op == 3) begin
                    e_clr = 1;
                    m_mode = M_IDLE;
                end else if (cal_done) begin
                    m_mode = M_IDLE;
                end
            end
            M_MOVE, M_GAP: begin
                if (!bmp_n) begin
                    e_go = 0; e_buzz = 1; e_lost = 0;
                    m_mode = M_STOP;
                end else if (valid && op == 3) begin
                    e_clr = 1; e_go = 0;
                    m_mode = M_IDLE;
                end else if (m_mode == M_MOVE) begin
                    if (fall) begin
                        t = (m_route.size() > 0) ? m_route.pop_front() : 3;
                        if (t == 3) begin
                            e_go = 0; e_done = 1;
                            m_mode = M_IDLE;
                        end else begin
                            m_turn = t; m_gap = 0;
                            e_vl = (t == 1); e_vr = (t == 2);
                            m_mode = M_GAP;
                        end
                    end
                end else if (line_present) begin
                    m_mode = M_MOVE;
                end else begin
                    m_gap++;
                    if (m_gap >= LIM) begin
                        e_go = 0; e_lost = 1; e_buzz = 1;
                        m_mode = M_STOP;
                    end else begin
                        e_vl = (m_turn == 1); e_vr = (m_turn == 2);
                    end
                end
            end
            M_STOP: begin
                if (valid) begin
                    e_clr = 1; e_lost = 0; e_buzz = 0;
                    m_mode = M_IDLE;
                end
            end
            default: m_mode = M_IDLE;
        endcase
        m_prev_line = line_present;
    endtask

    // ---- compare process ---------------------------------------------------
    always @(negedge clk) begin
        if (check_en)
            check("outputs", dut_outs(),
                  {e_go, e_clr, e_cal, e_vl, e_vr, e_done, e_lost, e_buzz});
    end

    // ---- stimulus helpers --------------------------------------------------
    // Upstream drops cmd_rdy one cycle after it sees the acknowledge.
    task automatic cyc();
        @(posedge clk);
        model_step();
        #2;
        if (clr_seen) cmd_rdy = 1'b0;
        clr_seen = clr_cmd_rdy;
    endtask

    task automatic send_cmd(input string name, input logic [15:0] c);
        bit acked;
        cmd = c;
        cmd_rdy = 1'b1;
        clr_seen = 1'b0;
        acked = 1'b0;
        for (int n = 0; n < 20 && !acked; n++) begin
            cyc();
            if (clr_cmd_rdy) acked = 1'b1;
        end
        check(name, acked, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b0; cmd = '0; cmd_rdy = 1'b0;
        line_present = 1'b1; bmp_n = 1'b1; cal_done = 1'b0;
        model_reset();
        #1;
        check("reset_outputs", dut_outs(), 8'h00);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        check_en = 1'b1;
        repeat (3) cyc();

        // Calibration handshake.
        send_cmd("cal_ack", 16'h0000);
        check("cal_strt", strt_cal, 1);
        cyc();
        check("cal_strt_pulse", strt_cal, 0);
        repeat (5) cyc();
        cal_done = 1'b1;
        cyc();
        cal_done = 1'b0;
        cyc();
        check("cal_go_low", go, 0);

        // Route 0x3FF9: left, right, then end (LSB pair first).
        send_cmd("go_ack_a", 16'h7FF9);
        check("go_high", go, 1);
        repeat (3) cyc();
        line_present = 1'b0;
        cyc();
        check("gap1_veer", {veer_lft, veer_rght}, 2'b10);
        repeat (99) cyc();
        line_present = 1'b1;
        cyc();
        check("gap1_return", {go, veer_lft, veer_rght}, 3'b100);
        repeat (5) cyc();
        line_present = 1'b0;
        cyc();
        check("gap2_veer", {veer_lft, veer_rght}, 2'b01);
        repeat (99) cyc();
        line_present = 1'b1;
        repeat (5) cyc();
        line_present = 1'b0;
        cyc();
        check("route_done_3", {go, route_done, veer_lft, veer_rght}, 4'b0100);
        line_present = 1'b1;
        cyc();
        check("route_done_pulse", route_done, 0);

        // Straight route: seven gaps, end on the eighth edge.
        send_cmd("go_ack_b", 16'h4000);
        repeat (2) cyc();
        for (int i = 0; i < 8; i++) begin
            line_present = 1'b0;
            cyc();
            if (i < 7) check("straight_gap", {go, veer_lft, veer_rght, route_done}, 4'b1000);
            else       check("route_end_8", {go, veer_lft, veer_rght, route_done}, 4'b0001);
            repeat (20) cyc();
            line_present = 1'b1;
            repeat (2) cyc();
        end

        // Gap timeout.
        send_cmd("go_ack_c", 16'h4000);
        repeat (2) cyc();
        line_present = 1'b0;
        cyc();
        n = 0;
        while (!lost_err && n < 5000) begin
            cyc();
            n++;
        end
        check("timeout_cycles", n, LIM);
        check("timeout_state", {go, lost_err, buzz_en}, 3'b011);
        line_present = 1'b1;
        repeat (3) cyc();
        send_cmd("stop_ack_a", 16'h8000);
        cyc();
        check("stop_cleared_a", {go, lost_err, buzz_en}, 3'b000);

        // Bumper on the same cycle as a line edge (left turn pending).
        send_cmd("go_ack_d", 16'h4001);
        repeat (2) cyc();
        line_present = 1'b0;
        bmp_n = 1'b0;
        cyc();
        check("bump_state", {go, veer_lft, veer_rght, buzz_en, lost_err}, 5'b00010);
        bmp_n = 1'b1;
        line_present = 1'b1;
        repeat (3) cyc();
        send_cmd("stop_ack_b", 16'h4000);
        repeat (2) cyc();
        check("stop_cleared_b", {go, buzz_en}, 2'b00);

        // Asynchronous reset mid-gap.
        send_cmd("go_ack_e", 16'h7FF9);
        repeat (2) cyc();
        line_present = 1'b0;
        cyc();
        repeat (10) cyc();
        check("pre_reset_veer", veer_lft, 1);
        check_en = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset", dut_outs(), 8'h00);
        model_reset();
        line_present = 1'b1;
        clr_seen = 1'b0;
        #3;
        rst_n = 1'b1;
        check_en = 1'b1;
        cyc();
        send_cmd("go_after_reset", 16'h4000);
        check("go_after_reset_go", go, 1);

        // Random phase.
        for (int i = 0; i < 6000; i++) begin
            if (!cmd_rdy && $urandom_range(15) == 0) begin
                cmd = 16'($urandom);
                cmd_rdy = 1'b1;
                clr_seen = 1'b0;
            end
            if ($urandom_range(14) == 0) line_present = ~line_present;
            bmp_n = ($urandom_range(199) != 0);
            cal_done = ($urandom_range(29) == 0);
            cyc();
        end
        bmp_n = 1'b1;
        cal_done = 1'b0;
        repeat (3) cyc();
        check_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
